// File: rtl/router_pkg.sv
// Shared definitions for the router's packet-aware output FIFO.
// Latency: n/a (package: sizing helpers, entry layout, tracker states, reset constants).
// Backpressure: n/a.
package router_pkg;

  // Address width for a given FIFO depth. Pointers carry one extra wrap bit on top of this.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of the payload-length field carried in a header byte.
  function automatic int len_w(input int lsb, input int msb);
    return msb - lsb + 1;
  endfunction

  // Each stored entry is {sop_flag, data}; the flag sits just above the data byte.
  function automatic int sop_pos(input int width);
    return width;
  endfunction

  // Values that reset/flush drive onto the single-bit registered outputs.
  localparam logic RST_BIT = 1'b0;

  // Read-side packet tracker state, derived from the remaining-byte counter.
  typedef enum logic {
    TRK_IDLE = 1'b0,  // no packet open, next byte must be a header
    TRK_OPEN = 1'b1   // inside a packet, bytes still owed before its end
  } trk_state_e;

endpackage

// File: rtl/router_pkt_len_tracker.sv
// Read-side packet boundary tracker: counts down header length + trailer, flags eop and framing errors.
// Latency: 1 cycle; outputs register alongside the FIFO's data_out so they line up with data_valid.
// Backpressure: none; advances only on accepted reads (rd_fire), holds otherwise.
//
// Ports:
//   clock, reset     clock and synchronous active-high full clear
//   flush            synchronous active-high flush; returns to IDLE without an error pulse
//   rd_fire          a FIFO read was accepted this cycle
//   rd_sop, rd_len   SOP flag and header length field of the entry being read
//   eop_out          byte delivered this cycle is the last of its packet
//   err_trunc        header arrived while the previous packet was still owed bytes
//   err_orphan       non-header byte arrived with no packet open
module router_pkt_len_tracker
  import router_pkg::*;
#(
  parameter int LEN_W   = 6,
  parameter int TRAILER = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             rd_fire,
  input  logic             rd_sop,
  input  logic [LEN_W-1:0] rd_len,
  output logic             eop_out,
  output logic             err_trunc,
  output logic             err_orphan
);

  logic [LEN_W:0] remain;
  logic [LEN_W:0] remain_nxt;
  logic [LEN_W:0] load_val;
  logic           eop_nxt;
  logic           trunc_nxt;
  logic           orphan_nxt;
  trk_state_e     state;

  // One extra bit on remain so len + trailer never overflows.
  assign load_val = {1'b0, rd_len} + (LEN_W+1)'(TRAILER);
  assign state    = (remain == '0) ? TRK_IDLE : TRK_OPEN;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      remain     <= '0;
      eop_out    <= RST_BIT;
      err_trunc  <= RST_BIT;
      err_orphan <= RST_BIT;
    end else begin
      remain     <= remain_nxt;
      eop_out    <= eop_nxt;
      err_trunc  <= trunc_nxt;
      err_orphan <= orphan_nxt;
    end
  end

  always_comb begin
    remain_nxt = remain;
    eop_nxt    = 1'b0;
    trunc_nxt  = 1'b0;
    orphan_nxt = 1'b0;
    if (rd_fire) begin
      unique case (state)
        TRK_IDLE: begin
          if (rd_sop) begin
            remain_nxt = load_val;
            // A zero-length packet with no trailer ends on its own header.
            eop_nxt    = (load_val == '0);
          end else begin
            orphan_nxt = 1'b1;
          end
        end
        TRK_OPEN: begin
          if (rd_sop) begin
            // New header cuts the open packet short; restart framing from it.
            trunc_nxt  = 1'b1;
            remain_nxt = load_val;
            eop_nxt    = (load_val == '0);
          end else begin
            remain_nxt = remain - (LEN_W+1)'(1);
            eop_nxt    = (remain == (LEN_W+1)'(1));
          end
        end
        default: remain_nxt = remain;
      endcase
    end
  end

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware per-port output FIFO: stores {sop, byte} entries, reports occupancy/watermarks, frames packets on read.
// Latency: 1 cycle from accepted read to data_out/data_valid; no fall-through on an empty FIFO.
// Backpressure: writes refused while full, reads refused while empty; both judged on pre-edge state.
//
// Ports:
//   clock, reset, soft_reset    clock, synchronous full clear, synchronous flush (same effect on state)
//   write_enb, sop_in, data_in  write side; sop_in tags the byte as a packet header
//   read_enb                    read request
//   data_out, data_valid        registered read byte and its 1-cycle valid
//   sop_out, eop_out            header / last-byte tags for data_out
//   full, empty, almost_full, almost_empty, count   occupancy status
//   err_trunc, err_orphan       1-cycle framing error pulses aligned with data_valid
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2,
  parameter int LEN_LSB   = 2,
  parameter int LEN_MSB   = 7,
  parameter int TRAILER   = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    soft_reset,
  input  logic                    write_enb,
  input  logic                    sop_in,
  input  logic [WIDTH-1:0]        data_in,
  input  logic                    read_enb,
  output logic [WIDTH-1:0]        data_out,
  output logic                    data_valid,
  output logic                    sop_out,
  output logic                    eop_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [addr_w(DEPTH):0]  count,
  output logic                    err_trunc,
  output logic                    err_orphan
);

  localparam int AW      = addr_w(DEPTH);
  localparam int LEN_W   = len_w(LEN_LSB, LEN_MSB);
  localparam int SOP_BIT = sop_pos(WIDTH);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_MARGIN);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_MARGIN);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("router_pkt_fifo: DEPTH must be a power of two and at least 4");
  end
  if ((LEN_MSB >= WIDTH) || (LEN_LSB > LEN_MSB)) begin : g_bad_len
    $error("router_pkt_fifo: length field must lie inside the data byte");
  end

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH:0]   rd_entry;
  logic [AW:0]      free_cnt;
  logic             flush_any;
  logic             wr_fire;
  logic             rd_fire;

  assign flush_any = reset || soft_reset;

  // Wrap bit distinguishes full from empty when the address bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Accepts are gated by the clears so nothing lands in storage during a flush.
  assign wr_fire = write_enb && !full  && !flush_any;
  assign rd_fire = read_enb  && !empty && !flush_any;

  assign rd_entry = mem[rd_ptr[AW-1:0]];

  assign free_cnt     = DEPTH_C - count;
  assign almost_full  = (free_cnt <= AF_C);
  assign almost_empty = (count <= AE_C);

  // Storage is deliberately not cleared; pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem[wr_ptr[AW-1:0]] <= {sop_in, data_in};
    end
  end

  always_ff @(posedge clock) begin
    if (flush_any) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      data_valid <= RST_BIT;
      sop_out    <= RST_BIT;
    end else begin
      data_valid <= rd_fire;
      if (wr_fire) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (rd_fire) begin
        rd_ptr   <= rd_ptr + (AW+1)'(1);
        // data_out and sop_out hold the last byte read while data_valid is low.
        data_out <= rd_entry[WIDTH-1:0];
        sop_out  <= rd_entry[SOP_BIT];
      end
      unique case ({wr_fire, rd_fire})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  router_pkt_len_tracker #(
    .LEN_W   (LEN_W),
    .TRAILER (TRAILER)
  ) u_len_tracker (
    .clock      (clock),
    .reset      (reset),
    .flush      (soft_reset),
    .rd_fire    (rd_fire),
    .rd_sop     (rd_entry[SOP_BIT]),
    .rd_len     (rd_entry[LEN_MSB:LEN_LSB]),
    .eop_out    (eop_out),
    .err_trunc  (err_trunc),
    .err_orphan (err_orphan)
  );

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Self-checking bench for router_pkt_fifo: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_router_pkt_fifo;

  localparam int DEPTH = 16;

  logic       clock;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       sop_in;
  logic [7:0] data_in;
  logic       read_enb;
  logic [7:0] data_out;
  logic       data_valid;
  logic       sop_out;
  logic       eop_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       err_trunc;
  logic       err_orphan;

  router_pkt_fifo dut (
    .clock        (clock),
    .reset        (reset),
    .soft_reset   (soft_reset),
    .write_enb    (write_enb),
    .sop_in       (sop_in),
    .data_in      (data_in),
    .read_enb     (read_enb),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .sop_out      (sop_out),
    .eop_out      (eop_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .err_trunc    (err_trunc),
    .err_orphan   (err_orphan)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a queue of entries plus a bytes-owed counter
  typedef struct packed {
    logic       sop;
    logic [7:0] d;
  } ent_t;

  ent_t       q[$];
  int         remain;
  logic       m_dv, m_sop, m_eop, m_tr, m_or;
  logic [7:0] m_do;

  task automatic model_update(input logic r, input logic sr, input logic we, input logic sp,
                              input logic [7:0] d, input logic re);
    ent_t e;
    bit   wr_ok, rd_ok;
    if (r || sr) begin
      q.delete();
      remain = 0;
      m_dv = 0; m_do = 0; m_sop = 0; m_eop = 0; m_tr = 0; m_or = 0;
      return;
    end
    wr_ok = we && (q.size() < DEPTH);
    rd_ok = re && (q.size() > 0);
    m_dv = rd_ok; m_eop = 0; m_tr = 0; m_or = 0;
    if (rd_ok) begin
      e = q.pop_front();
      m_do  = e.d;
      m_sop = e.sop;
      if (e.sop) begin
        m_tr   = (remain > 0);
        remain = int'(e.d[7:2]) + 1;
        m_eop  = (remain == 0);
      end else if (remain == 0) begin
        m_or = 1;
      end else begin
        remain--;
        m_eop = (remain == 0);
      end
    end
    if (wr_ok) q.push_back('{sop: sp, d: d});
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_data_valid"},   data_valid,   m_dv);
    chk({tag, "_data_out"},     data_out,     m_do);
    chk({tag, "_sop_out"},      sop_out,      m_sop);
    chk({tag, "_eop_out"},      eop_out,      m_eop);
    chk({tag, "_err_trunc"},    err_trunc,    m_tr);
    chk({tag, "_err_orphan"},   err_orphan,   m_or);
    chk({tag, "_count"},        count,        q.size());
    chk({tag, "_empty"},        empty,        q.size() == 0);
    chk({tag, "_full"},         full,         q.size() == DEPTH);
    chk({tag, "_almost_full"},  almost_full,  (DEPTH - q.size()) <= 2);
    chk({tag, "_almost_empty"}, almost_empty, q.size() <= 2);
  endtask

  // Drive one cycle, advance the model on the same pre-edge inputs, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic sr, input logic we, input logic sp,
                      input logic [7:0] d, input logic re, input string tag);
    reset = r; soft_reset = sr; write_enb = we; sop_in = sp; data_in = d; read_enb = re;
    model_update(r, sr, we, sp, d, re);
    @(posedge clock);
    #1;
    check_model(tag);
  endtask

  // ---------------- directed vector table
  typedef struct {
    logic       rst, srst, we, sp;
    logic [7:0] din;
    logic       re;
    logic       dv;
    logic [7:0] dout;
    logic       so, eo, tr, orr;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic rst, input logic srst, input logic we, input logic sp,
                      input logic [7:0] din, input logic re, input logic dv, input logic [7:0] dout,
                      input logic so, input logic eo, input logic tr, input logic orr, input int cnt);
    vecs.push_back('{rst, srst, we, sp, din, re, dv, dout, so, eo, tr, orr, cnt});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1; soft_reset = 0; write_enb = 0; sop_in = 0; data_in = 0; read_enb = 0;
    remain = 0;

    //    rst srst we sp din    re | dv dout   so eo tr or cnt
    // reset with writes/reads pending
    addv(1, 0, 1, 1, 8'hAA, 0,   0, 8'h00, 0, 0, 0, 0, 0);
    addv(1, 0, 1, 0, 8'hBB, 1,   0, 8'h00, 0, 0, 0, 0, 0);
    // header 0x0C (len 3) + 3 payload + parity, then read 5
    addv(0, 0, 1, 1, 8'h0C, 0,   0, 8'h00, 0, 0, 0, 0, 1);
    addv(0, 0, 1, 0, 8'h11, 0,   0, 8'h00, 0, 0, 0, 0, 2);
    addv(0, 0, 1, 0, 8'h22, 0,   0, 8'h00, 0, 0, 0, 0, 3);
    addv(0, 0, 1, 0, 8'h33, 0,   0, 8'h00, 0, 0, 0, 0, 4);
    addv(0, 0, 1, 0, 8'h44, 0,   0, 8'h00, 0, 0, 0, 0, 5);
    addv(0, 0, 0, 0, 8'h00, 1,   1, 8'h0C, 1, 0, 0, 0, 4);
    addv(0, 0, 0, 0, 8'h00, 1,   1, 8'h11, 0, 0, 0, 0, 3);
    addv(0, 0, 0, 0, 8'h00, 1,   1, 8'h22, 0, 0, 0, 0, 2);
    addv(0, 0, 0, 0, 8'h00, 1,   1, 8'h33, 0, 0, 0, 0, 1);
    addv(0, 0, 0, 0, 8'h00, 1,   1, 8'h44, 0, 1, 0, 0, 0);
    addv(0, 0, 0, 0, 8'h00, 0,   0, 8'h44, 0, 0, 0, 0, 0);
    // header len 3, two payload bytes, then a new header len 2 -> truncation on 2nd header
    addv(0, 0, 1, 1, 8'h0C, 0,   0, 8'h44, 0, 0, 0, 0, 1);
    addv(0, 0, 1, 0, 8'h01, 0,   0, 8'h44, 0, 0, 0, 0, 2);
    addv(0, 0, 1, 0, 8'h02, 0,   0, 8'h44, 0, 0, 0, 0, 3);
    addv(0, 0, 1, 1, 8'h08, 0,   0, 8'h44, 0, 0, 0, 0, 4);
    addv(0, 0, 0, 0, 8'h00, 1,   1, 8'h0C, 1, 0, 0, 0, 3);
    addv(0, 0, 0, 0, 8'h00, 1,   1, 8'h01, 0, 0, 0, 0, 2);
    addv(0, 0, 0, 0, 8'h00, 1,   1, 8'h02, 0, 0, 0, 0, 1);
    addv(0, 0, 0, 0, 8'h00, 1,   1, 8'h08, 1, 0, 1, 0, 0);
    // non-header byte after reset -> orphan
    addv(1, 0, 0, 0, 8'h00, 0,   0, 8'h00, 0, 0, 0, 0, 0);
    addv(0, 0, 1, 0, 8'h5A, 0,   0, 8'h00, 0, 0, 0, 0, 1);
    addv(0, 0, 0, 0, 8'h00, 1,   1, 8'h5A, 0, 0, 0, 1, 0);
    addv(0, 0, 0, 0, 8'h00, 0,   0, 8'h5A, 0, 0, 0, 0, 0);
    // write+read on empty: read refused; then a len-0 packet ends on its parity byte
    addv(0, 0, 1, 1, 8'h00, 1,   0, 8'h5A, 0, 0, 0, 0, 1);
    addv(0, 0, 0, 0, 8'h00, 1,   1, 8'h00, 1, 0, 0, 0, 0);
    addv(0, 0, 1, 0, 8'h77, 0,   0, 8'h00, 1, 0, 0, 0, 1);
    addv(0, 0, 0, 0, 8'h00, 1,   1, 8'h77, 0, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      step(v.rst, v.srst, v.we, v.sp, v.din, v.re, $sformatf("vec%0d_model", i));
      chk($sformatf("vec%0d_data_valid", i), data_valid, v.dv);
      chk($sformatf("vec%0d_data_out", i),   data_out,   v.dout);
      chk($sformatf("vec%0d_sop_out", i),    sop_out,    v.so);
      chk($sformatf("vec%0d_eop_out", i),    eop_out,    v.eo);
      chk($sformatf("vec%0d_err_trunc", i),  err_trunc,  v.tr);
      chk($sformatf("vec%0d_err_orphan", i), err_orphan, v.orr);
      chk($sformatf("vec%0d_count", i),      count,      v.cnt);
    end

    // ---------------- fill to full, refused writes at full, drain in order
    step(1, 0, 0, 0, 8'h00, 0, "fill_rst");
    chk("fill_rst_empty", empty, 1);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, 0, 8'(i * 3 + 1), 0, $sformatf("fill%0d", i));
      chk($sformatf("fill%0d_almost_full", i), almost_full, (i + 1) >= 14);
    end
    chk("fill_full", full, 1);
    step(0, 0, 1, 0, 8'hEE, 0, "full_wr");
    chk("full_wr_count", count, 16);
    step(0, 0, 1, 0, 8'hEF, 1, "full_wr_rd");
    chk("full_wr_rd_count", count, 15);
    chk("full_wr_rd_data", data_out, 8'h01);
    for (int i = 1; i < DEPTH; i++) begin
      step(0, 0, 0, 0, 8'h00, 1, $sformatf("drain%0d", i));
      chk($sformatf("drain%0d_data", i), data_out, 8'(i * 3 + 1));
    end
    chk("drain_empty", empty, 1);
    step(0, 0, 0, 0, 8'h00, 1, "drain_extra");
    chk("drain_extra_valid", data_valid, 0);

    // ---------------- streaming through pointer wrap with constant occupancy
    step(1, 0, 0, 0, 8'h00, 0, "strm_rst");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'($urandom), 0, $sformatf("strm_prime%0d", i));
    for (int i = 0; i < 70; i++) begin
      step(0, 0, 1, 0, 8'($urandom), 1, $sformatf("strm%0d", i));
      chk($sformatf("strm%0d_count", i), count, 3);
    end

    // ---------------- soft reset in the middle of a packet
    step(1, 0, 0, 0, 8'h00, 0, "soft_rst0");
    step(0, 0, 1, 1, 8'h0C, 0, "soft_hdr");
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 8'(8'h20 + i), 0, $sformatf("soft_wr%0d", i));
    step(0, 0, 0, 0, 8'h00, 1, "soft_rd");
    chk("soft_count7", count, 7);
    step(0, 1, 1, 1, 8'h0C, 1, "soft_flush");
    chk("soft_flush_count", count, 0);
    chk("soft_flush_empty", empty, 1);
    chk("soft_flush_valid", data_valid, 0);
    chk("soft_flush_trunc", err_trunc, 0);
    chk("soft_flush_orphan", err_orphan, 0);
    step(0, 0, 0, 0, 8'h00, 0, "soft_after");

    // ---------------- randomized traffic
    step(1, 0, 0, 0, 8'h00, 0, "rnd_rst");
    for (int i = 0; i < 600; i++) begin
      logic sr, we, sp, re;
      logic [7:0] d;
      sr = ($urandom_range(0, 59) == 0);
      we = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 50);
      sp = ($urandom_range(0, 3) == 0);
      d  = 8'($urandom) & 8'h1F;
      step(0, sr, we, sp, d, re, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
